// File: rtl/sdram_addr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_addr_pkg
//  Description : Shared widths and types for the SDRAM address generator:
//                bank/row/column field widths, linear pointer and word count.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdram_addr_pkg;

  localparam int c_ba_w    = 2;
  localparam int c_row_w   = 13;
  localparam int c_col_w   = 9;
  localparam int c_addr_w  = c_ba_w + c_row_w + c_col_w;  // 24-bit linear pointer
  localparam int c_count_w = c_addr_w + 1;                // holds END_ADDR+1 words

  typedef logic [c_addr_w-1:0]  addr_t;
  typedef logic [c_count_w-1:0] count_t;

endpackage
`default_nettype wire

// File: rtl/sdram_address_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_address_gen_if
//  Description : Bundle between the memory controller (master) and the
//                address generator (slave): advance strobes in, pointer
//                fields and fill status out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sdram_address_gen_if;
  import sdram_addr_pkg::*;

  logic                 NEXT_WRITE;
  logic                 NEXT_READ;
  logic [c_ba_w-1:0]    BA_WRITE;
  logic [c_row_w-1:0]   ROW_WRITE;
  logic [c_col_w-1:0]   COL_WRITE;
  logic [c_ba_w-1:0]    BA_READ;
  logic [c_row_w-1:0]   ROW_READ;
  logic [c_col_w-1:0]   COL_READ;
  logic [c_count_w-1:0] WORD_COUNT;
  logic                 EMPTY;
  logic                 FULL;
  logic                 OVERFLOW;
  logic                 UNDERFLOW;

  modport master (
    output NEXT_WRITE, NEXT_READ,
    input  BA_WRITE, ROW_WRITE, COL_WRITE, BA_READ, ROW_READ, COL_READ,
    input  WORD_COUNT, EMPTY, FULL, OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  NEXT_WRITE, NEXT_READ,
    output BA_WRITE, ROW_WRITE, COL_WRITE, BA_READ, ROW_READ, COL_READ,
    output WORD_COUNT, EMPTY, FULL, OVERFLOW, UNDERFLOW
  );

endinterface
`default_nettype wire

// File: rtl/sdram_addr_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_addr_ptr
//  Description : One linear SDRAM word pointer. Advances by one when asked,
//                wrapping from END_ADDR to 0, and presents the value split
//                into bank / row / column (column fastest).
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_addr_ptr
  import sdram_addr_pkg::*;
#(
  parameter addr_t END_ADDR = 24'hFFFFFF
) (
  input  wire logic               CLK_48MHZ,
  input  wire logic               RESET,
  input  wire logic               i_advance,
  output logic [c_ba_w-1:0]       o_ba,
  output logic [c_row_w-1:0]      o_row,
  output logic [c_col_w-1:0]      o_col
);

  addr_t r_ptr;
  addr_t w_ptr_inc;

  // Next pointer value: only END_ADDR wraps, everything else counts up.
  always_comb begin
    w_ptr_inc = (r_ptr == END_ADDR) ? '0 : r_ptr + 1'b1;
  end

  // Pointer register.
  always_ff @(posedge CLK_48MHZ) begin
    if (RESET) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= w_ptr_inc;
    end
  end

  assign o_ba  = r_ptr[c_addr_w-1 -: c_ba_w];
  assign o_row = r_ptr[c_col_w +: c_row_w];
  assign o_col = r_ptr[c_col_w-1:0];

endmodule
`default_nettype wire

// File: rtl/sdram_address_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_address_gen
//  Description : Write/read address generator for an SDRAM used as a FIFO.
//                Rising edges of NEXT_WRITE / NEXT_READ advance the pointers,
//                a word counter tracks fill level, and sticky flags record
//                overflow and underflow attempts.
//                Build option ADDR_GEN_OVERWRITE_EN: a write while full
//                discards the oldest word instead of being ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_address_gen
  import sdram_addr_pkg::*;
#(
  parameter addr_t END_ADDR = 24'hFFFFFF
) (
  input  wire logic          CLK_48MHZ,
  input  wire logic          RESET,
  sdram_address_gen_if.slave bus
);

  localparam count_t c_full_count = count_t'({1'b0, END_ADDR}) + count_t'(1);

  logic   r_next_write_q, r_next_read_q;
  // Hold-off flags: a strobe already high in the last reset cycle must not
  // look like a fresh edge once reset is released.
  logic   r_write_hold, r_read_hold;
  count_t r_word_count;
  logic   r_empty, r_full, r_overflow, r_underflow;

  logic   w_write_ev, w_read_ev;
  logic   w_adv_write, w_adv_read;
  count_t w_count_next;
  logic   w_set_ovf, w_set_unf;

  assign w_write_ev = bus.NEXT_WRITE & ~r_next_write_q & ~r_write_hold;
  assign w_read_ev  = bus.NEXT_READ  & ~r_next_read_q  & ~r_read_hold;

  // Decide pointer advances, next count and flag events for this edge.
  always_comb begin
    w_adv_write  = 1'b0;
    w_adv_read   = 1'b0;
    w_count_next = r_word_count;
    w_set_ovf    = 1'b0;
    w_set_unf    = 1'b0;
    case ({w_write_ev, w_read_ev})
      2'b11: begin
        w_adv_write = 1'b1;
        if (r_empty) begin
          // Nothing to read yet: the write lands, the read is refused.
          w_count_next = r_word_count + count_t'(1);
          w_set_unf    = 1'b1;
        end else begin
          w_adv_read = 1'b1;
        end
      end
      2'b10: begin
        if (!r_full) begin
          w_adv_write  = 1'b1;
          w_count_next = r_word_count + count_t'(1);
        end else begin
          w_set_ovf = 1'b1;
`ifdef ADDR_GEN_OVERWRITE_EN
          w_adv_write = 1'b1;
          w_adv_read  = 1'b1;
`endif
        end
      end
      2'b01: begin
        if (!r_empty) begin
          w_adv_read   = 1'b1;
          w_count_next = r_word_count - count_t'(1);
        end else begin
          w_set_unf = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Edge registers, fill count, status and sticky flags.
  always_ff @(posedge CLK_48MHZ) begin
    if (RESET) begin
      r_next_write_q <= 1'b0;
      r_next_read_q  <= 1'b0;
      r_write_hold   <= bus.NEXT_WRITE;
      r_read_hold    <= bus.NEXT_READ;
      r_word_count   <= '0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      r_next_write_q <= bus.NEXT_WRITE;
      r_next_read_q  <= bus.NEXT_READ;
      r_write_hold   <= 1'b0;
      r_read_hold    <= 1'b0;
      r_word_count   <= w_count_next;
      r_empty        <= (w_count_next == '0);
      r_full         <= (w_count_next == c_full_count);
      r_overflow     <= r_overflow  | w_set_ovf;
      r_underflow    <= r_underflow | w_set_unf;
    end
  end

  sdram_addr_ptr #(.END_ADDR(END_ADDR)) u_write_ptr (
    .CLK_48MHZ (CLK_48MHZ),
    .RESET     (RESET),
    .i_advance (w_adv_write),
    .o_ba      (bus.BA_WRITE),
    .o_row     (bus.ROW_WRITE),
    .o_col     (bus.COL_WRITE)
  );

  sdram_addr_ptr #(.END_ADDR(END_ADDR)) u_read_ptr (
    .CLK_48MHZ (CLK_48MHZ),
    .RESET     (RESET),
    .i_advance (w_adv_read),
    .o_ba      (bus.BA_READ),
    .o_row     (bus.ROW_READ),
    .o_col     (bus.COL_READ)
  );

  assign bus.WORD_COUNT = r_word_count;
  assign bus.EMPTY      = r_empty;
  assign bus.FULL       = r_full;
  assign bus.OVERFLOW   = r_overflow;
  assign bus.UNDERFLOW  = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sdram_address_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_address_gen
//  Description : Self-checking bench: a full-size instance and a 16-word
//                instance share one stimulus stream; both are compared every
//                cycle against a linear-pointer FIFO model, with directed
//                scenarios pinned by literal expectations.
//                Honours ADDR_GEN_OVERWRITE_EN like the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_address_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic nw  = 1'b0;
  logic nr  = 1'b0;

  always #10 clk = ~clk;

  sdram_address_gen_if if0 ();
  sdram_address_gen_if if1 ();

  assign if0.NEXT_WRITE = nw;
  assign if0.NEXT_READ  = nr;
  assign if1.NEXT_WRITE = nw;
  assign if1.NEXT_READ  = nr;

  sdram_address_gen #(.END_ADDR(24'hFFFFFF)) u_big (
    .CLK_48MHZ (clk),
    .RESET     (rst),
    .bus       (if0)
  );

  sdram_address_gen #(.END_ADDR(24'h00000F)) u_small (
    .CLK_48MHZ (clk),
    .RESET     (rst),
    .bus       (if1)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model: linear pointers and a plain integer fill count.
  logic [23:0] m_wp  [2];
  logic [23:0] m_rp  [2];
  int          m_cnt [2];
  bit          m_ovf [2];
  bit          m_unf [2];
  int          m_cap [2];
  bit          prev_w, prev_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [23:0] bump(input logic [23:0] p, input int cap);
    return (int'(p) == cap - 1) ? 24'd0 : p + 24'd1;
  endfunction

  task automatic model_step(input bit r, input bit w, input bit rd);
    bit wev, rev, full, empty;
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        m_wp[i] = '0; m_rp[i] = '0; m_cnt[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
      end
      // A level present at reset release is not an edge.
      prev_w = w; prev_r = rd;
      return;
    end
    wev = w && !prev_w;
    rev = rd && !prev_r;
    prev_w = w; prev_r = rd;
    for (int i = 0; i < 2; i++) begin
      full  = (m_cnt[i] == m_cap[i]);
      empty = (m_cnt[i] == 0);
      if (wev && rev) begin
        m_wp[i] = bump(m_wp[i], m_cap[i]);
        if (empty) begin m_cnt[i]++; m_unf[i] = 1; end
        else m_rp[i] = bump(m_rp[i], m_cap[i]);
      end else if (wev) begin
        if (!full) begin
          m_wp[i] = bump(m_wp[i], m_cap[i]); m_cnt[i]++;
        end else begin
          m_ovf[i] = 1;
`ifdef ADDR_GEN_OVERWRITE_EN
          m_wp[i] = bump(m_wp[i], m_cap[i]);
          m_rp[i] = bump(m_rp[i], m_cap[i]);
`endif
        end
      end else if (rev) begin
        if (!empty) begin m_rp[i] = bump(m_rp[i], m_cap[i]); m_cnt[i]--; end
        else m_unf[i] = 1;
      end
    end
  endtask

  task automatic cmp_one(input int i,
                         input logic [1:0] baw, input logic [12:0] roww, input logic [8:0] colw,
                         input logic [1:0] bar, input logic [12:0] rowr, input logic [8:0] colr,
                         input logic [24:0] wc, input logic e, input logic f,
                         input logic o, input logic u);
    string p;
    p = (i == 0) ? "big" : "small";
    chk({p, " write_ptr"},  {8'd0, baw, roww, colw}, {8'd0, m_wp[i]});
    chk({p, " read_ptr"},   {8'd0, bar, rowr, colr}, {8'd0, m_rp[i]});
    chk({p, " word_count"}, {7'd0, wc}, m_cnt[i]);
    chk({p, " empty"},      {31'd0, e}, {31'd0, m_cnt[i] == 0});
    chk({p, " full"},       {31'd0, f}, {31'd0, m_cnt[i] == m_cap[i]});
    chk({p, " overflow"},   {31'd0, o}, {31'd0, m_ovf[i]});
    chk({p, " underflow"},  {31'd0, u}, {31'd0, m_unf[i]});
  endtask

  // One clock: drive at the falling edge, step the model at the rising edge,
  // compare both instances at the next falling edge.
  task automatic tick(input bit r, input bit w, input bit rd);
    rst = r; nw = w; nr = rd;
    @(posedge clk);
    model_step(r, w, rd);
    @(negedge clk);
    cmp_one(0, if0.BA_WRITE, if0.ROW_WRITE, if0.COL_WRITE, if0.BA_READ, if0.ROW_READ,
            if0.COL_READ, if0.WORD_COUNT, if0.EMPTY, if0.FULL, if0.OVERFLOW, if0.UNDERFLOW);
    cmp_one(1, if1.BA_WRITE, if1.ROW_WRITE, if1.COL_WRITE, if1.BA_READ, if1.ROW_READ,
            if1.COL_READ, if1.WORD_COUNT, if1.EMPTY, if1.FULL, if1.OVERFLOW, if1.UNDERFLOW);
  endtask

  task automatic pulse(input bit w, input bit rd);
    tick(0, w, rd);
    tick(0, 0, 0);
  endtask

  task automatic do_reset();
    tick(1, 0, 0);
    tick(1, 0, 0);
  endtask

  initial begin
    m_cap[0] = 24'hFFFFFF + 1;
    m_cap[1] = 16;
    prev_w = 0; prev_r = 0;
    @(negedge clk);

    // Reset state
    do_reset();
    chk("reset empty", {31'd0, if0.EMPTY}, 32'd1);
    chk("reset full", {31'd0, if1.FULL}, 32'd0);
    chk("reset count", {7'd0, if0.WORD_COUNT}, 32'd0);

    // Three write pulses; first update visible one cycle after its edge
    tick(0, 1, 0);
    chk("first write col", {23'd0, if0.COL_WRITE}, 32'd1);
    tick(0, 0, 0);
    pulse(1, 0);
    pulse(1, 0);
    chk("3 writes col", {23'd0, if0.COL_WRITE}, 32'd3);
    chk("3 writes count", {7'd0, if0.WORD_COUNT}, 32'd3);
    chk("3 writes empty", {31'd0, if0.EMPTY}, 32'd0);

    // Column to row carry
    do_reset();
    for (int k = 0; k < 'h1FF; k++) pulse(1, 0);
    chk("pre-carry col", {23'd0, if0.COL_WRITE}, 32'h1FF);
    chk("pre-carry row", {19'd0, if0.ROW_WRITE}, 32'd0);
    pulse(1, 0);
    chk("carry row", {19'd0, if0.ROW_WRITE}, 32'd1);
    chk("carry col", {23'd0, if0.COL_WRITE}, 32'd0);
    chk("carry count", {7'd0, if0.WORD_COUNT}, 32'h200);

    // Full and overflow on the 16-word instance
    do_reset();
    for (int k = 0; k < 16; k++) pulse(1, 0);
    chk("16 writes full", {31'd0, if1.FULL}, 32'd1);
    chk("16 writes count", {7'd0, if1.WORD_COUNT}, 32'd16);
    chk("16 writes no ovf", {31'd0, if1.OVERFLOW}, 32'd0);
    pulse(1, 0);
    chk("17th write ovf", {31'd0, if1.OVERFLOW}, 32'd1);
    chk("17th write count", {7'd0, if1.WORD_COUNT}, 32'd16);
`ifdef ADDR_GEN_OVERWRITE_EN
    chk("overwrite read ptr", {8'd0, if1.BA_READ, if1.ROW_READ, if1.COL_READ}, 32'd1);
    chk("overwrite write ptr", {8'd0, if1.BA_WRITE, if1.ROW_WRITE, if1.COL_WRITE}, 32'd1);
`else
    chk("ignored read ptr", {8'd0, if1.BA_READ, if1.ROW_READ, if1.COL_READ}, 32'd0);
    chk("ignored write ptr", {8'd0, if1.BA_WRITE, if1.ROW_WRITE, if1.COL_WRITE}, 32'd0);
`endif

    // Read while empty
    do_reset();
    pulse(0, 1);
    chk("underflow flag", {31'd0, if0.UNDERFLOW}, 32'd1);
    chk("underflow count", {7'd0, if0.WORD_COUNT}, 32'd0);
    chk("underflow read col", {23'd0, if0.COL_READ}, 32'd0);
    chk("underflow write col", {23'd0, if0.COL_WRITE}, 32'd0);

    // Simultaneous write and read at count 5
    do_reset();
    for (int k = 0; k < 5; k++) pulse(1, 0);
    pulse(1, 1);
    chk("simul write col", {23'd0, if0.COL_WRITE}, 32'd6);
    chk("simul read col", {23'd0, if0.COL_READ}, 32'd1);
    chk("simul count", {7'd0, if0.WORD_COUNT}, 32'd5);

    // Strobe held high across reset is not an edge
    tick(1, 1, 0);
    tick(1, 1, 0);
    for (int k = 0; k < 4; k++) tick(0, 1, 0);
    chk("held write col", {23'd0, if0.COL_WRITE}, 32'd0);
    chk("held write count", {7'd0, if0.WORD_COUNT}, 32'd0);
    tick(0, 0, 0);
    tick(0, 1, 0);
    chk("after held, new edge", {7'd0, if0.WORD_COUNT}, 32'd1);

    // Rise in the first cycle after reset, low during reset, is an edge
    tick(1, 0, 0);
    tick(0, 1, 0);
    chk("first cycle edge", {7'd0, if0.WORD_COUNT}, 32'd1);
    tick(0, 0, 0);

    // Randomized traffic: write-biased, then read-biased, with rare resets
    for (int k = 0; k < 3000; k++) begin
      bit r, w, rd;
      r  = ($urandom_range(0, 299) == 0);
      if (k < 1500) begin
        w  = ($urandom_range(0, 1) == 1);
        rd = ($urandom_range(0, 3) == 0);
      end else begin
        w  = ($urandom_range(0, 3) == 0);
        rd = ($urandom_range(0, 1) == 1);
      end
      tick(r, w, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdram_address_gen.md
SDRAM_ADDRESS_GEN -- requirements
Module: sdram_address_gen

Interface
REQ-001 SHALL have parameter END_ADDR, default 24'hFFFFFF: last usable linear word address; pointers wrap to 0 after it.
REQ-002 SHALL have port CLK_48MHZ, input, 1: single system clock; all logic on its rising edge.
REQ-003 SHALL have port RESET, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port NEXT_WRITE, input, 1: level from the memory controller; a rising edge advances the write pointer.
REQ-005 SHALL have port NEXT_READ, input, 1: level from the memory controller; a rising edge advances the read pointer.
REQ-006 SHALL have ports BA_WRITE (output, 2), ROW_WRITE (output, 13) and COL_WRITE (output, 9): write pointer fields.
REQ-007 SHALL have ports BA_READ (output, 2), ROW_READ (output, 13) and COL_READ (output, 9): read pointer fields.
REQ-008 SHALL have port WORD_COUNT, output, 25: number of words written and not yet read.
REQ-009 SHALL have ports EMPTY (output, 1, WORD_COUNT==0) and FULL (output, 1, WORD_COUNT==END_ADDR+1).
REQ-010 SHALL have ports OVERFLOW (output, 1, sticky) and UNDERFLOW (output, 1, sticky): protection event flags.

Function
REQ-011 SHALL map each 24-bit linear pointer as {BA[1:0], ROW[12:0], COL[8:0]}: column increments fastest, then row, then bank.
REQ-012 SHALL register NEXT_WRITE and NEXT_READ each cycle; an advance event SHALL be input==1 while the registered previous value==0.
REQ-013 SHALL update the pointer, WORD_COUNT and flags on the same clock edge at which the event is detected; the new values are visible the following cycle.
REQ-014 SHALL increment a pointer equal to END_ADDR to 0 (wrap); no other value SHALL wrap.
REQ-015 SHALL increment the write pointer and WORD_COUNT on a write-only event when not FULL.
REQ-016 SHALL increment the read pointer and decrement WORD_COUNT on a read-only event when not EMPTY.
REQ-017 SHALL leave all state unchanged on a read-only event while EMPTY, and SHALL set UNDERFLOW.
REQ-018 SHALL advance both pointers on simultaneous write and read events, with WORD_COUNT unchanged.
REQ-019 SHALL advance only the write pointer on simultaneous events while EMPTY, with WORD_COUNT +1 and UNDERFLOW set.
REQ-020 SHALL handle a write-only event while FULL as defined in REQ-025/REQ-026.
REQ-021 SHALL drive outputs directly from registers, with no combinational path from NEXT_* to any output.

Reset
REQ-022 SHALL, while RESET==1 at a clock edge, clear both pointers, WORD_COUNT, OVERFLOW, UNDERFLOW and both edge registers to 0; EMPTY=1 and FULL=0.
REQ-023 SHALL give RESET priority over any simultaneous event; an event coincident with reset is lost.
REQ-024 SHALL NOT detect a NEXT_* input held high through reset release as an edge.

Configuration
REQ-025 SHALL, with ADDR_GEN_OVERWRITE_EN defined, advance both pointers on a write-only event while FULL (oldest word discarded), keep WORD_COUNT full and set OVERFLOW.
REQ-026 SHALL, without ADDR_GEN_OVERWRITE_EN, ignore a write-only event while FULL (no pointer or count change) and set OVERFLOW.

Structure
REQ-027 SHALL take field widths (BA 2, ROW 13, COL 9), the 24-bit linear width and the 25-bit count width from the shared package sdram_addr_pkg.
REQ-028 SHALL implement each pointer (register, increment, END_ADDR wrap, field split) in sub-module sdram_addr_ptr, instantiated twice.

Verification
REQ-029 SHALL verify that 3 NEXT_WRITE pulses after reset give COL_WRITE=3, WORD_COUNT=3 and EMPTY=0, with each update one cycle after its edge.
REQ-030 SHALL verify that a write pointer at linear 24'h0001FF followed by one write pulse gives ROW_WRITE=1 and COL_WRITE=0.
REQ-031 SHALL verify, with END_ADDR=24'h00000F, that 16 writes give FULL=1 and a 17th write sets OVERFLOW; the bench SHALL also check that read pointer=1 with the macro defined and write pointer=0 with read pointer=0 without it.
REQ-032 SHALL verify that a NEXT_READ pulse while EMPTY sets UNDERFLOW with pointers and count unchanged.
REQ-033 SHALL verify that simultaneous NEXT_WRITE and NEXT_READ rises at WORD_COUNT=5 advance both pointers by 1 with WORD_COUNT=5.
REQ-034 SHALL verify that NEXT_WRITE held high across a RESET pulse produces no advance after release.
